// File: rtl/riscv_pkg.sv
// Shared constants and types for the decode-side register file and its scoreboard.
// Also holds the pending-flag helper used by both read ports.
package riscv_pkg;

    localparam int XLEN           = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int NUM_REGS       = 32;

    typedef logic [1:0] sb_cnt_t;

    // A source is pending unless its only outstanding producer retires this cycle
    // via the bypass path (and that producer is not simultaneously squashed).
    function automatic logic src_pending(
        input sb_cnt_t                   cnt,
        input logic [REG_ADDR_WIDTH-1:0] src_addr,
        input logic                      wb_en,
        input logic [REG_ADDR_WIDTH-1:0] wb_addr,
        input logic                      kill_en,
        input logic [REG_ADDR_WIDTH-1:0] kill_addr
    );
        logic retiring;
        retiring = (cnt == 2'd1) && wb_en && (wb_addr == src_addr)
                   && !(kill_en && (kill_addr == src_addr));
        return (src_addr != {REG_ADDR_WIDTH{1'b0}}) && (cnt != 2'd0) && !retiring;
    endfunction

endpackage

// File: rtl/sb_counter.sv
// One saturating 2-bit in-flight counter; overflow/underflow are single-cycle pulses
// that the parent accumulates into sticky flags.
module sb_counter
    import riscv_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    inc,
    input  logic    dec_wb,
    input  logic    dec_kill,
    output sb_cnt_t cnt,
    output logic    ovf,
    output logic    unf
);

    sb_cnt_t    r_cnt;
    sb_cnt_t    w_next;
    logic [2:0] w_plus;
    logic [2:0] w_minus;
    logic [2:0] w_diff;

    // Sum all three events, then clamp to 0..3 and flag any clamp.
    always_comb begin
        w_plus  = {1'b0, r_cnt} + {2'b00, inc};
        w_minus = {2'b00, dec_wb} + {2'b00, dec_kill};
        w_diff  = w_plus - w_minus;
        w_next  = r_cnt;
        ovf     = 1'b0;
        unf     = 1'b0;
        if (w_plus < w_minus) begin
            w_next = 2'd0;
            unf    = 1'b1;
        end else if (w_diff > 3'd3) begin
            w_next = 2'd3;
            ovf    = 1'b1;
        end else begin
            w_next = w_diff[1:0];
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 2'd0;
        end else begin
            r_cnt <= w_next;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/reg_file.sv
// Architectural register file x0..x31 with writeback bypass on both read ports and
// a per-register in-flight scoreboard that drives the decode stall flags.
module reg_file
    import riscv_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    output logic [XLEN-1:0]           rs1_data,
    output logic [XLEN-1:0]           rs2_data,
    output logic                      rs1_pending,
    output logic                      rs2_pending,
    input  logic                      wb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
    input  logic [XLEN-1:0]           wb_write_data,
    input  logic                      sb_set,
    input  logic [REG_ADDR_WIDTH-1:0] sb_set_addr,
    input  logic                      sb_kill,
    input  logic [REG_ADDR_WIDTH-1:0] sb_kill_addr,
    output logic                      sb_overflow,
    output logic                      sb_underflow
);

    logic [XLEN-1:0]     r_regs [NUM_REGS];
    sb_cnt_t             w_cnt  [NUM_REGS];
    logic [NUM_REGS-1:0] w_ovf;
    logic [NUM_REGS-1:0] w_unf;
    logic                w_wb_hit;
    logic                r_overflow;
    logic                r_underflow;

    assign w_wb_hit = wb_reg_write && (wb_rd_addr != {REG_ADDR_WIDTH{1'b0}});

    // Storage: x0 is never written, so it only ever holds the reset value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= {XLEN{1'b0}};
            end
        end else if (w_wb_hit) begin
            r_regs[wb_rd_addr] <= wb_write_data;
        end
    end

    // Read ports with same-cycle writeback bypass.
    always_comb begin
        rs1_data = {XLEN{1'b0}};
        rs2_data = {XLEN{1'b0}};
        if (rs1_addr == {REG_ADDR_WIDTH{1'b0}}) begin
            rs1_data = {XLEN{1'b0}};
        end else if (w_wb_hit && (wb_rd_addr == rs1_addr)) begin
            rs1_data = wb_write_data;
        end else begin
            rs1_data = r_regs[rs1_addr];
        end
        if (rs2_addr == {REG_ADDR_WIDTH{1'b0}}) begin
            rs2_data = {XLEN{1'b0}};
        end else if (w_wb_hit && (wb_rd_addr == rs2_addr)) begin
            rs2_data = wb_write_data;
        end else begin
            rs2_data = r_regs[rs2_addr];
        end
    end

    assign w_cnt[0] = 2'd0;
    assign w_ovf[0] = 1'b0;
    assign w_unf[0] = 1'b0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_sb
        sb_counter u_cnt (
            .clk      (clk),
            .reset    (reset),
            .inc      (sb_set       && (sb_set_addr  == REG_ADDR_WIDTH'(g))),
            .dec_wb   (wb_reg_write && (wb_rd_addr   == REG_ADDR_WIDTH'(g))),
            .dec_kill (sb_kill      && (sb_kill_addr == REG_ADDR_WIDTH'(g))),
            .cnt      (w_cnt[g]),
            .ovf      (w_ovf[g]),
            .unf      (w_unf[g])
        );
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= r_overflow  | (|w_ovf);
            r_underflow <= r_underflow | (|w_unf);
        end
    end

    assign sb_overflow  = r_overflow;
    assign sb_underflow = r_underflow;

    assign rs1_pending = src_pending(w_cnt[rs1_addr], rs1_addr, wb_reg_write, wb_rd_addr,
                                     sb_kill, sb_kill_addr);
    assign rs2_pending = src_pending(w_cnt[rs2_addr], rs2_addr, wb_reg_write, wb_rd_addr,
                                     sb_kill, sb_kill_addr);

endmodule

// File: doc/reg_file.md
# reg_file

Decode-side architectural register file: the write end of the writeback interface. It holds x1–x31 with x0 hard-wired to zero, serves two combinational read ports to the decode stage with same-cycle writeback bypass, and accepts one write per cycle from the writeback stage. An integrated per-register pending-write scoreboard (2-bit in-flight counters) tells decode when a source operand still has an older producer in flight, so hazard logic can stall.

## Interface
Parameters (from `riscv_pkg`):
- `XLEN`, default 32: data width.
- `REG_ADDR_WIDTH`, default 5: register address width; 32 entries.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `rs1_addr`, `rs2_addr`  in  REG_ADDR_WIDTH  decode source addresses.
- `rs1_data`, `rs2_data`  out  XLEN  read data, combinational.
- `rs1_pending`, `rs2_pending`  out  1  source still has an in-flight producer.
- `wb_reg_write`  in  1  writeback write enable, already qualified by the valid bit.
- `wb_rd_addr`  in  REG_ADDR_WIDTH  writeback destination.
- `wb_write_data`  in  XLEN  writeback data.
- `sb_set`  in  1  decode issues an instruction that writes `sb_set_addr`.
- `sb_set_addr`  in  REG_ADDR_WIDTH  destination being issued.
- `sb_kill`  in  1  a previously issued writer of `sb_kill_addr` was squashed.
- `sb_kill_addr`  in  REG_ADDR_WIDTH  destination of the squashed instruction.
- `sb_overflow`  out  1  sticky error: increment attempted at count 3.
- `sb_underflow`  out  1  sticky error: decrement attempted at count 0.

## Operation
- **Storage.** 31 XLEN entries. A write to x0 is discarded. Reads of x0 return 0, and `rsN_pending` for x0 is always 0.
- **Write.** When `wb_reg_write` is 1 and `wb_rd_addr` is non-zero, `regs[wb_rd_addr] <= wb_write_data` at the edge.
- **Read bypass.** If `wb_reg_write` is 1, `wb_rd_addr` is non-zero and `wb_rd_addr == rsN_addr`, then `rsN_data = wb_write_data`. Otherwise `rsN_data = regs[rsN_addr]`.
- **Scoreboard.** Each register x1–x31 has a count `cnt` in 0..3.
  - Per-cycle delta for register r = +(`sb_set` at r) − (`wb_reg_write` at r) − (`sb_kill` at r). All three events may target the same r in one cycle; they are summed, giving a delta in −2..+1.
  - A delta of +1 when `cnt == 3` leaves the count at 3 and sets `sb_overflow`.
  - A result below 0 clamps to 0 and sets `sb_underflow`.
  - Events addressed to x0 are ignored.
- **Pending.** `rsN_pending = (cnt[rsN] != 0) && !(cnt[rsN] == 1 && wb_reg_write && wb_rd_addr == rsN_addr && !(sb_kill && sb_kill_addr == rsN_addr))`.
  - A last producer retiring this cycle is covered by the bypass, so decode does not stall.
  - `sb_set` in the current cycle does not affect the current cycle's pending output.

## Timing
- Read data and pending flags are combinational from the addresses, registered state and WB inputs: zero latency.
- Register contents, counts and error flags update at the rising edge: one-cycle latency.
- **Reset.** All registers clear to 0, all counts to 0, `sb_overflow = 0`, `sb_underflow = 0`.
  - While `reset` is high, writes, sets and kills in that cycle are discarded.
  - The combinational outputs follow the cleared state from the cycle after the reset edge.
- The error flags clear only on reset.

## Structure
- `XLEN`, `REG_ADDR_WIDTH`, `NUM_REGS` (32) and a `sb_cnt_t` (2-bit) typedef belong in `riscv_pkg`.
- Sub-module `sb_counter`: one saturating 2-bit counter.
  - Inputs: `inc`, `dec_wb`, `dec_kill`.
  - Outputs: `cnt`, `ovf`, `unf`.
  - Instantiated 31 times via generate. The parent ORs the `ovf`/`unf` pulses into the sticky flags.

## Test plan
1. **Reset state.** Assert `reset` with `wb_reg_write = 1`, `wb_rd_addr = 5`, data `0xDEADBEEF` → after release, x5 reads 0, all pending 0, both error flags 0.
2. **Write and bypass.** Write x7 = `0x12345678` while `rs1_addr = 7` → `rs1_data = 0x12345678` in the same cycle. The next cycle it reads from storage. A write to x0 with `0xFFFFFFFF` → x0 still reads 0.
3. **Scoreboard.**
   - `sb_set` x3 twice → `rs2_pending` for x3 is 1.
   - First WB to x3 → still pending.
   - Second WB to x3: pending 0 in that same cycle, and `rs2_data` shows the bypassed value.
4. **Simultaneous events.**
   - x9 at count 1, with `sb_set`, WB and `sb_kill` all on x9 → count becomes 0, no error.
   - x9 at count 1, with `sb_set` and WB on x9 → count stays 1.
5. **Saturation.**
   - Four `sb_set` to x12 → count 3, `sb_overflow = 1` and it stays 1.
   - `sb_kill` x4 at count 0 → `sb_underflow = 1`, count stays 0.
6. **Reset mid-operation.** x20 at count 2 with stored `0xA5A5A5A5`; assert reset for one cycle → count 0, data 0, flags 0.
